// File: rtl/adc_telemetry_sampler.sv
//-----------------------------------------------------------------------------
// adc_telemetry_sampler
//
// Periodic snapshot stage behind the ADC78H90 interface block. Once per
// INTERVAL clocks it closes the current peak interval on AIN1/AIN2 through
// the pk_detect_reset / pk_detect_ack handshake. It also captures AIN3..AIN6
// and smooths them with an exponential moving average. It then offers one
// coherent six-channel snapshot to the packet builder over valid/ready.
//
// Parameters
//   INTERVAL   clocks between snapshot requests (>= 256, > 2*TIMEOUT+3)
//   TIMEOUT    max clocks spent waiting for each ack edge
//   EMA_SHIFT  EMA weight 2^-EMA_SHIFT on AIN3..AIN6 (1..6)
//
// Ports
//   clock, reset_n        system clock, asynchronous active-low reset
//   AIN1..AIN6            channel values from the ADC block (12 bit)
//   pk_detect_ack         ack from the ADC block
//   pk_detect_reset       peak-interval reset request (registered, high in REQ)
//   snap_ready            consumer accepts the snapshot
//   flag_clear            single-cycle clear of overrun / ack_timeout
//   snap_valid            snapshot available
//   snap_ain1..snap_ain6  snapshot data: peaks on 1-2, EMA on 3-6
//   overrun               sticky: an unaccepted snapshot was overwritten
//   ack_timeout           sticky: a handshake phase timed out
//-----------------------------------------------------------------------------
module adc_telemetry_sampler #(
  parameter int INTERVAL  = 30720,
  parameter int TIMEOUT   = 1024,
  parameter int EMA_SHIFT = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [11:0] AIN1,
  input  logic [11:0] AIN2,
  input  logic [11:0] AIN3,
  input  logic [11:0] AIN4,
  input  logic [11:0] AIN5,
  input  logic [11:0] AIN6,
  input  logic        pk_detect_ack,
  output logic        pk_detect_reset,
  input  logic        snap_ready,
  input  logic        flag_clear,
  output logic        snap_valid,
  output logic [11:0] snap_ain1,
  output logic [11:0] snap_ain2,
  output logic [11:0] snap_ain3,
  output logic [11:0] snap_ain4,
  output logic [11:0] snap_ain5,
  output logic [11:0] snap_ain6,
  output logic        overrun,
  output logic        ack_timeout
);

  localparam int DATA_W = 12;
  localparam int ACC_W  = DATA_W + EMA_SHIFT;
  localparam int CNT_W  = $clog2(INTERVAL);
  localparam int TMO_W  = $clog2(TIMEOUT) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERVAL - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2,
    UPD  = 2'd3
  } state_t;

  // EMA accumulator step; the true result always fits in ACC_W bits, so
  // any intermediate wrap of the modular sum cancels out.
  function automatic logic [ACC_W-1:0] ema_step(input logic [ACC_W-1:0]  acc,
                                                input logic [DATA_W-1:0] x);
    return acc + ACC_W'(x) - ACC_W'(acc >> EMA_SHIFT);
  endfunction

  // First sample after reset seeds the accumulator at full weight.
  function automatic logic [ACC_W-1:0] ema_prime(input logic [DATA_W-1:0] x);
    return {x, {EMA_SHIFT{1'b0}}};
  endfunction

  // Truncating scale-down of the accumulator to the output width.
  function automatic logic [DATA_W-1:0] ema_out(input logic [ACC_W-1:0] acc);
    return acc[ACC_W-1:EMA_SHIFT];
  endfunction

  logic [DATA_W-1:0] ain [6];
  assign ain[0] = AIN1;
  assign ain[1] = AIN2;
  assign ain[2] = AIN3;
  assign ain[3] = AIN4;
  assign ain[4] = AIN5;
  assign ain[5] = AIN6;

  state_t            state, state_next;
  logic [CNT_W-1:0]  interval_cnt;
  logic              tick;
  logic              tick_pending;
  logic [TMO_W-1:0]  wait_cnt;
  logic              tmo_hit;
  logic              capture;
  logic              set_tmo;
  logic              clr_pending;
  logic              primed;

  logic [DATA_W-1:0] hold_p0  [6];
  logic [ACC_W-1:0]  acc_p1   [4];
  logic [ACC_W-1:0]  acc_next [4];
  logic [DATA_W-1:0] snap_p1  [6];

  assign tick    = (interval_cnt == CNT_LAST);
  assign tmo_hit = (wait_cnt == TMO_LAST);

  // Free-running interval counter and the one-deep tick latch. A new tick
  // wins over the IDLE consume in the same cycle so it is not lost.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      interval_cnt <= '0;
      tick_pending <= 1'b0;
    end else begin
      interval_cnt <= tick ? '0 : interval_cnt + CNT_W'(1);
      if (tick)
        tick_pending <= 1'b1;
      else if (clr_pending)
        tick_pending <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    set_tmo     = 1'b0;
    clr_pending = 1'b0;
    case (state)
      IDLE: begin
        if (tick_pending) begin
          clr_pending = 1'b1;
          state_next  = REQ;
        end
      end
      REQ: begin
        // Sampling on the ack cycle itself is what gives the closing
        // interval's peak on AIN1/AIN2.
        if (pk_detect_ack) begin
          capture    = 1'b1;
          state_next = REL;
        end else if (tmo_hit) begin
          capture    = 1'b1;
          set_tmo    = 1'b1;
          state_next = REL;
        end
      end
      REL: begin
        if (!pk_detect_ack) begin
          state_next = UPD;
        end else if (tmo_hit) begin
          set_tmo    = 1'b1;
          state_next = UPD;
        end
      end
      UPD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-phase wait counter; restarts on every state change.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      wait_cnt <= '0;
    else if (state_next != state)
      wait_cnt <= '0;
    else if (state == REQ || state == REL)
      wait_cnt <= wait_cnt + TMO_W'(1);
  end

  // Registered request, high exactly while the FSM sits in REQ.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      pk_detect_reset <= 1'b0;
    else
      pk_detect_reset <= (state_next == REQ);
  end

  // ---- stage p0: capture on ack (or timeout) ----
  always_ff @(posedge clock) begin
    if (capture) begin
      for (int k = 0; k < 6; k++)
        hold_p0[k] <= ain[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++)
      acc_next[k] = primed ? ema_step(acc_p1[k], hold_p0[k+2])
                           : ema_prime(hold_p0[k+2]);
  end

  // ---- stage p1: EMA update and snapshot load in UPD ----
  always_ff @(posedge clock) begin
    if (state == UPD) begin
      for (int k = 0; k < 4; k++)
        acc_p1[k] <= acc_next[k];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      primed <= 1'b0;
      for (int k = 0; k < 6; k++)
        snap_p1[k] <= '0;
    end else if (state == UPD) begin
      primed     <= 1'b1;
      snap_p1[0] <= hold_p0[0];
      snap_p1[1] <= hold_p0[1];
      for (int k = 0; k < 4; k++)
        snap_p1[k+2] <= ema_out(acc_next[k]);
    end
  end

  // A snapshot load keeps valid high even when the old one is accepted in
  // the same cycle; only an unaccepted overwrite counts as overrun.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snap_valid  <= 1'b0;
      overrun     <= 1'b0;
      ack_timeout <= 1'b0;
    end else begin
      if (state == UPD)
        snap_valid <= 1'b1;
      else if (snap_valid && snap_ready)
        snap_valid <= 1'b0;

      if (state == UPD && snap_valid && !snap_ready)
        overrun <= 1'b1;
      else if (flag_clear)
        overrun <= 1'b0;

      if (set_tmo)
        ack_timeout <= 1'b1;
      else if (flag_clear)
        ack_timeout <= 1'b0;
    end
  end

  assign snap_ain1 = snap_p1[0];
  assign snap_ain2 = snap_p1[1];
  assign snap_ain3 = snap_p1[2];
  assign snap_ain4 = snap_p1[3];
  assign snap_ain5 = snap_p1[4];
  assign snap_ain6 = snap_p1[5];

endmodule

// File: tb/tb_adc_telemetry_sampler.sv
module tb_adc_telemetry_sampler;

  localparam int INTERVAL  = 567;   // multiple of the 81-clock ADC frame
  localparam int TIMEOUT   = 128;
  localparam int EMA_SHIFT = 3;
  localparam int PERIOD    = 10;

  typedef int six_t [6];

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        snap_ready = 1'b1;
  logic        flag_clear = 1'b0;
  logic        pk_detect_reset;
  logic        snap_valid;
  logic        overrun;
  logic        ack_timeout;
  logic [11:0] snap_ain1, snap_ain2, snap_ain3, snap_ain4, snap_ain5, snap_ain6;
  logic [11:0] snap [6];

  int errors = 0;
  int checks = 0;

  // ADC block model state
  int          adc_cnt = 0;
  int          ack_mode = 0;      // 0 normal, 1 never acks, 2 ack stuck high
  bit          rand_mode = 1'b0;
  logic [11:0] const_ain [6];
  logic [11:0] ain_r [6];
  logic        ack_r = 1'b0;
  logic [71:0] adc_nv;
  logic [71:0] cap_q [$];

  // Reference EMA state
  int m_acc [6];
  bit m_primed = 1'b0;

  always #(PERIOD/2) clock = ~clock;

  adc_telemetry_sampler #(
    .INTERVAL (INTERVAL),
    .TIMEOUT  (TIMEOUT),
    .EMA_SHIFT(EMA_SHIFT)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .AIN1           (ain_r[0]),
    .AIN2           (ain_r[1]),
    .AIN3           (ain_r[2]),
    .AIN4           (ain_r[3]),
    .AIN5           (ain_r[4]),
    .AIN6           (ain_r[5]),
    .pk_detect_ack  (ack_r),
    .pk_detect_reset(pk_detect_reset),
    .snap_ready     (snap_ready),
    .flag_clear     (flag_clear),
    .snap_valid     (snap_valid),
    .snap_ain1      (snap_ain1),
    .snap_ain2      (snap_ain2),
    .snap_ain3      (snap_ain3),
    .snap_ain4      (snap_ain4),
    .snap_ain5      (snap_ain5),
    .snap_ain6      (snap_ain6),
    .overrun        (overrun),
    .ack_timeout    (ack_timeout)
  );

  always_comb begin
    snap[0] = snap_ain1;
    snap[1] = snap_ain2;
    snap[2] = snap_ain3;
    snap[3] = snap_ain4;
    snap[4] = snap_ain5;
    snap[5] = snap_ain6;
  end

  // ADC block: channel values and ack change only at the frame's state-0
  // cycle. The values present when ack rises are what the sampler must take.
  always @(posedge clock) begin
    adc_cnt <= (adc_cnt == 80) ? 0 : adc_cnt + 1;
    if (adc_cnt == 0) begin
      for (int k = 0; k < 6; k++) begin
        adc_nv[k*12 +: 12] = rand_mode ? 12'($urandom_range(0, 4095)) : const_ain[k];
        ain_r[k] <= adc_nv[k*12 +: 12];
      end
      if (ack_mode == 0) begin
        if (pk_detect_reset && !ack_r)
          cap_q.push_back(adc_nv);
        ack_r <= pk_detect_reset;
      end
    end
    if (ack_mode == 1)
      ack_r <= 1'b0;
    else if (ack_mode == 2)
      ack_r <= 1'b1;
  end

  // Snapshot expected from one set of captured channel values.
  task automatic model_snap(input logic [71:0] c, output six_t e);
    int x;
    for (int k = 0; k < 6; k++) begin
      x = int'(c[k*12 +: 12]);
      if (k < 2) begin
        e[k] = x;
      end else begin
        if (!m_primed)
          m_acc[k] = x * (1 << EMA_SHIFT);
        else
          m_acc[k] = m_acc[k] + x - m_acc[k] / (1 << EMA_SHIFT);
        e[k] = m_acc[k] / (1 << EMA_SHIFT);
      end
    end
    m_primed = 1'b1;
  endtask

  function automatic logic [71:0] pack_const();
    logic [71:0] v;
    for (int k = 0; k < 6; k++)
      v[k*12 +: 12] = const_ain[k];
    return v;
  endfunction

  task automatic pop_cap(output logic [71:0] c);
    c = '0;
    if (cap_q.size() != 0)
      c = cap_q.pop_front();
  endtask

  // Follows one normal handshake and returns at the negedge of the cycle in
  // which the new snapshot is visible. Called from a negedge.
  task automatic wait_snap(input bit ready_in_upd, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (pk_detect_reset !== 1'b1 && n < 2*INTERVAL) begin @(negedge clock); n++; end
    if (pk_detect_reset !== 1'b1) return;
    n = 0;
    while (pk_detect_reset !== 1'b0 && n < TIMEOUT + 8) begin @(negedge clock); n++; end
    if (pk_detect_reset !== 1'b0) return;
    n = 0;
    while (ack_r !== 1'b0 && n < TIMEOUT + 8) begin @(negedge clock); n++; end
    if (ack_r !== 1'b0) return;
    @(posedge clock);
    if (ready_in_upd) begin
      @(negedge clock);
      snap_ready = 1'b1;
    end
    @(posedge clock);
    @(negedge clock);
    ok = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    const_ain[0] = 12'h7A0; const_ain[1] = 12'h123; const_ain[2] = 12'h400;
    const_ain[3] = 12'h9C4; const_ain[4] = 12'h555; const_ain[5] = 12'hFFF;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({pk_detect_reset, snap_valid, overrun, ack_timeout} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000", {pk_detect_reset, snap_valid, overrun, ack_timeout});
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (snap[k] !== 12'h000) begin
        errors++;
        $display("FAIL reset_snap_ain%0d: got %h required 000", k+1, snap[k]);
      end
    end
    reset_n = 1'b1;
    n = 0;
    while (pk_detect_reset !== 1'b1 && n < 2*INTERVAL) begin @(negedge clock); n++; end
    checks++;
    if (n != INTERVAL + 1) begin
      errors++;
      $display("FAIL reset_first_req_latency: got %0d cycles required %0d", n, INTERVAL + 1);
    end
  endtask

  task automatic test_constant();
    bit ok;
    logic [71:0] c;
    six_t e;
    time t_prev = 0;
    for (int s = 0; s < 3; s++) begin
      wait_snap(1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL const_wait: no snapshot within budget"); end
      pop_cap(c);
      model_snap(c, e);
      checks++;
      if (snap_valid !== 1'b1) begin errors++; $display("FAIL const_valid: got %b required 1", snap_valid); end
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (snap[k] !== 12'(e[k])) begin
          errors++;
          $display("FAIL const_snap_ain%0d: got %h required %h", k+1, snap[k], 12'(e[k]));
        end
      end
      checks++;
      if (snap_ain1 !== 12'h7A0 || snap_ain3 !== 12'h400) begin
        errors++;
        $display("FAIL const_peak_level: got %h/%h required 7a0/400", snap_ain1, snap_ain3);
      end
      if (s > 0) begin
        checks++;
        if ($time - t_prev != time'(INTERVAL * PERIOD)) begin
          errors++;
          $display("FAIL const_spacing: got %0t required %0t", $time - t_prev, time'(INTERVAL * PERIOD));
        end
      end
      t_prev = $time;
    end
    checks++;
    if ({overrun, ack_timeout} !== 2'b00) begin
      errors++;
      $display("FAIL const_flags: got %b required 00", {overrun, ack_timeout});
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [71:0] c;
    six_t e;
    rand_mode = 1'b1;
    for (int s = 0; s < 5; s++) begin
      wait_snap(1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand_wait: no snapshot within budget"); end
      pop_cap(c);
      model_snap(c, e);
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (snap[k] !== 12'(e[k])) begin
          errors++;
          $display("FAIL rand_snap_ain%0d: got %h required %h", k+1, snap[k], 12'(e[k]));
        end
      end
    end
    rand_mode = 1'b0;
  endtask

  task automatic test_ack_never();
    int n, hi;
    six_t e;
    ack_mode = 1;
    n = 0;
    while (pk_detect_reset !== 1'b1 && n < 2*INTERVAL) begin @(negedge clock); n++; end
    hi = 0;
    while (pk_detect_reset === 1'b1 && hi < TIMEOUT + 10) begin @(negedge clock); hi++; end
    checks++;
    if (hi != TIMEOUT) begin errors++; $display("FAIL never_req_len: got %0d required %0d", hi, TIMEOUT); end
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    model_snap(pack_const(), e);
    checks++;
    if ({snap_valid, ack_timeout} !== 2'b11) begin
      errors++;
      $display("FAIL never_valid_timeout: got %b required 11", {snap_valid, ack_timeout});
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (snap[k] !== 12'(e[k])) begin
        errors++;
        $display("FAIL never_snap_ain%0d: got %h required %h", k+1, snap[k], 12'(e[k]));
      end
    end
    flag_clear = 1'b1;
    @(negedge clock);
    flag_clear = 1'b0;
    checks++;
    if (ack_timeout !== 1'b0) begin errors++; $display("FAIL never_flag_clear: got %b required 0", ack_timeout); end
    ack_mode = 0;
  endtask

  task automatic test_ack_stuck();
    int n, hi, lo;
    six_t e;
    ack_mode = 2;
    n = 0;
    while (pk_detect_reset !== 1'b1 && n < 2*INTERVAL) begin @(negedge clock); n++; end
    hi = 0;
    while (pk_detect_reset === 1'b1 && hi < TIMEOUT + 10) begin @(negedge clock); hi++; end
    checks++;
    if (hi != 1) begin errors++; $display("FAIL stuck_req_len: got %0d required 1", hi); end
    lo = 0;
    while (snap_valid !== 1'b1 && lo < TIMEOUT + 10) begin @(negedge clock); lo++; end
    checks++;
    if (lo != TIMEOUT + 1) begin errors++; $display("FAIL stuck_rel_len: got %0d required %0d", lo, TIMEOUT + 1); end
    model_snap(pack_const(), e);
    checks++;
    if (ack_timeout !== 1'b1) begin errors++; $display("FAIL stuck_timeout: got %b required 1", ack_timeout); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (snap[k] !== 12'(e[k])) begin
        errors++;
        $display("FAIL stuck_snap_ain%0d: got %h required %h", k+1, snap[k], 12'(e[k]));
      end
    end
    flag_clear = 1'b1;
    @(negedge clock);
    flag_clear = 1'b0;
    checks++;
    if (ack_timeout !== 1'b0) begin errors++; $display("FAIL stuck_flag_clear: got %b required 0", ack_timeout); end
    ack_mode = 0;
  endtask

  task automatic test_overrun();
    bit ok;
    logic [71:0] c;
    six_t e;
    rand_mode = 1'b1;
    snap_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      wait_snap(1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ovr_wait: no snapshot within budget"); end
      pop_cap(c);
      model_snap(c, e);
      checks++;
      if ({snap_valid, overrun} !== {1'b1, s == 1}) begin
        errors++;
        $display("FAIL ovr_valid_flag%0d: got %b required %b", s, {snap_valid, overrun}, {1'b1, s == 1});
      end
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (snap[k] !== 12'(e[k])) begin
        errors++;
        $display("FAIL ovr_snap_ain%0d: got %h required %h", k+1, snap[k], 12'(e[k]));
      end
    end
    flag_clear = 1'b1;
    @(negedge clock);
    flag_clear = 1'b0;
    checks++;
    if ({snap_valid, overrun} !== 2'b10) begin
      errors++;
      $display("FAIL ovr_flag_clear: got %b required 10", {snap_valid, overrun});
    end
    rand_mode = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [71:0] c;
    six_t e;
    rand_mode = 1'b1;
    wait_snap(1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_wait: no snapshot within budget"); end
    pop_cap(c);
    model_snap(c, e);
    checks++;
    if ({snap_valid, overrun} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_valid_flag: got %b required 10", {snap_valid, overrun});
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (snap[k] !== 12'(e[k])) begin
        errors++;
        $display("FAIL b2b_snap_ain%0d: got %h required %h", k+1, snap[k], 12'(e[k]));
      end
    end
    @(negedge clock);
    checks++;
    if (snap_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b required 0", snap_valid); end
    rand_mode = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    int n;
    bit ok;
    logic [71:0] c;
    six_t e;
    const_ain[3] = 12'h800;
    n = 0;
    while (pk_detect_reset !== 1'b1 && n < 2*INTERVAL) begin @(negedge clock); n++; end
    checks++;
    if (pk_detect_reset !== 1'b1) begin errors++; $display("FAIL rst_mid_req_seen: got %b required 1", pk_detect_reset); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({pk_detect_reset, snap_valid, overrun, ack_timeout} !== 4'b0) begin
      errors++;
      $display("FAIL rst_mid_ctrl: got %b required 0000", {pk_detect_reset, snap_valid, overrun, ack_timeout});
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (snap[k] !== 12'h000) begin
        errors++;
        $display("FAIL rst_mid_snap_ain%0d: got %h required 000", k+1, snap[k]);
      end
    end
    repeat (3) @(negedge clock);
    cap_q.delete();
    m_primed = 1'b0;
    reset_n = 1'b1;
    n = 0;
    while (pk_detect_reset !== 1'b1 && n < 2*INTERVAL) begin @(negedge clock); n++; end
    checks++;
    if (n != INTERVAL + 1) begin
      errors++;
      $display("FAIL rst_mid_req_latency: got %0d cycles required %0d", n, INTERVAL + 1);
    end
    wait_snap(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_mid_wait: no snapshot within budget"); end
    pop_cap(c);
    model_snap(c, e);
    checks++;
    if (snap_ain4 !== 12'h800) begin errors++; $display("FAIL rst_mid_prime: got %h required 800", snap_ain4); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (snap[k] !== 12'(e[k])) begin
        errors++;
        $display("FAIL rst_mid_snap_ain%0d: got %h required %h", k+1, snap[k], 12'(e[k]));
      end
    end
  endtask

  task automatic test_ema_decay();
    bit ok;
    logic [71:0] c;
    six_t e;
    logic [11:0] want [3];
    want[0] = 12'h700;
    want[1] = 12'h620;
    want[2] = 12'h55C;
    const_ain[3] = 12'h000;
    for (int s = 0; s < 3; s++) begin
      wait_snap(1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ema_wait: no snapshot within budget"); end
      pop_cap(c);
      model_snap(c, e);
      checks++;
      if (snap_ain4 !== want[s]) begin
        errors++;
        $display("FAIL ema_step%0d: got %h required %h", s, snap_ain4, want[s]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 6; k++) begin
      ain_r[k] = 12'h000;
      m_acc[k] = 0;
    end
    test_reset();
    test_constant();
    test_random();
    test_ack_never();
    test_ack_stuck();
    test_overrun();
    test_back_to_back();
    test_reset_mid_req();
    test_ema_decay();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(100000 * PERIOD);
    $display("FAIL watchdog: simulation exceeded %0d cycles", 100000);
    $fatal(1);
  end

endmodule
